seg_scan_bin: RTL and testbench
===============================

Name: seg_scan_bin

Overview:
Parametrised multiplexed seven-segment driver for N common-anode digits.
- Takes an unsigned binary value and converts it to BCD with a sequential shift-and-add-3 engine.
- Drives one digit per scan slot at a programmable refresh rate.
- Adds overflow indication, per-digit decimal points, and display blanking.
- Replaces fixed 4-digit, combinational-divide display drivers in board top levels.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
WIDTH, 16, bit width of the binary input num (1..32)
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
num  in  WIDTH  unsigned binary value to display
dp  in  DIGITS  per-digit decimal point, active-high; bit i belongs to digit i
blank  in  1  1 = all anodes off
anodes  out  DIGITS  one-hot digit enable, active-high; bit DIGITS-1 = leftmost digit
cathodes  out  8  active-low segments, {a,b,c,d,e,f,g,dp}; bit 7 = a, bit 0 = dp
upd  out  1  one-cycle pulse when the display register loads a new conversion

Behaviour:
Reset (rst_n=0, asynchronous):
- anodes=0, cathodes=8'hFF, upd=0.
- Display register = 0, overflow flag = 0.
- Prescaler = 0, scan index = DIGITS-1, converter FSM = IDLE.

Converter FSM (runs continuously):
- IDLE, one cycle: capture num into a shift register, clear the 4*DIGITS-bit BCD accumulator and the sticky overflow flag. Go to SHIFT.
- SHIFT, exactly WIDTH cycles, once per iteration:
  - Add 3 to every BCD nibble >= 5.
  - Shift {bcd, bin} left by one.
  - If the bit shifted out of the BCD MSB is 1, set sticky overflow.
  - After WIDTH iterations go to LOAD.
- LOAD, one cycle: copy the BCD accumulator and the overflow flag to the display register, pulse upd=1, return to IDLE.

Timing:
- One conversion every WIDTH+2 cycles.
- A change on num is visible in the display register within 2*(WIDTH+2) cycles.
- num is sampled only in IDLE; changes during SHIFT do not corrupt the result in flight.

Overflow:
- Set when num >= 10^DIGITS.
- While set, every digit shows '-' (segment g only). dp still applies.

Scan:
- The prescaler counts 0..REFRESH_DIV-1.
- On wrap the scan index decrements: DIGITS-1 down to 0, then back to DIGITS-1.
- Output stage is registered every cycle from the current index, display register, dp and blank (1-cycle latency):
  - anodes = blank ? 0 : one-hot(index).
  - cathodes = ~{seg(digit[index]), dp[index]}.
- Active-high segment codes {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other nibble = 0000000.

Boundaries:
- DIGITS=1: index stays 0.
- A display register update mid-slot takes effect on the next cycle without resetting the scan.
- Reset asserted mid-conversion aborts it; the display register returns to 0.

Optional Feature:
Macro SEG_LZB_EN enables leading-zero blanking.
- Defined: digits above the most significant nonzero digit show segments all off. dp is still honoured and anodes still scan. Digit 0 is never blanked, so num=0 shows a single "0". Overflow display is unaffected.
- Undefined: all digits show their value, including leading zeros.

Test Plan:
1. Reset, then num=1234, DIGITS=4, REFRESH_DIV=4.
   -> upd pulses at cycle 18 after release, then every 18 cycles.
   -> anodes cycle 1000,0100,0010,0001 with 4 cycles each.
   -> cathodes = ~{seg(1),0}, ~{seg(2),0}, ~{seg(3),0}, ~{seg(4),0}.
2. num=9999, then num=10000.
   -> after the next upd, all digits show cathodes = 8'b11111101 ('-').
   -> num=9999 shows four 9s.
3. num=42, dp=4'b0100.
   -> without SEG_LZB_EN: 0,0.,4,2.
   -> with SEG_LZB_EN: digit 3 = 8'hFF, digit 2 = 8'hFE (blank, dp only), then 4, 2. num=0 shows only digit 0 = "0".
4. Toggle blank=1 for 10 cycles mid-scan.
   -> anodes=0 one cycle after blank rises; the scan index keeps advancing; the scan resumes at the correct slot.
5. Drop rst_n during SHIFT of a conversion for num=5678.
   -> outputs go to reset values immediately, with no clock edge needed.
   -> after release, the first upd shows 5678.
6. Parameters WIDTH=8, DIGITS=2, num=8'd255.
   -> overflow, shown as '--'.
   -> num=8'd99 shows "99" after upd (WIDTH+2=10-cycle period).

Source files
------------

// File: rtl/seg_scan_bin.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_bin
// Brief    : Binary-to-BCD multiplexed 7-seg driver; SEG_LZB_EN = leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seg_scan_bin #(
   parameter int DIGITS      = 4,
   parameter int WIDTH       = 16,
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  num,
   input  logic [DIGITS-1:0] dp,
   input  logic              blank,
   output logic [DIGITS-1:0] anodes,
   output logic [7:0]        cathodes,
   output logic              upd
);

   localparam int c_bcd_w = 4 * DIGITS;
   localparam int c_iw    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_pw    = $clog2(REFRESH_DIV);
   localparam int c_cw    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_bin;
   logic [c_bcd_w-1:0]   r_bcd;
   logic [c_bcd_w-1:0]   w_adj;
   logic [c_bcd_w-1:0]   r_disp;
   logic                 r_ovf_acc;
   logic                 r_ovf;
   logic [c_cw-1:0]      r_cnt;
   logic [c_pw-1:0]      r_presc;
   logic [c_iw-1:0]      r_idx;
   logic [3:0]           w_digit;
   logic                 w_dp;
   logic                 w_lzb;
   logic [DIGITS-1:0]    w_onehot;
   logic [6:0]           w_seg;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1111110;
         4'd1:    seg7 = 7'b0110000;
         4'd2:    seg7 = 7'b1101101;
         4'd3:    seg7 = 7'b1111001;
         4'd4:    seg7 = 7'b0110011;
         4'd5:    seg7 = 7'b1011011;
         4'd6:    seg7 = 7'b1011111;
         4'd7:    seg7 = 7'b1110000;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1111011;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   // Double-dabble correction applied to every nibble before the shift
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_ovf_acc <= 1'b0;
         r_cnt     <= '0;
         r_disp    <= '0;
         r_ovf     <= 1'b0;
         upd       <= 1'b0;
      end else begin
         upd <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_bin     <= num;
               r_bcd     <= '0;
               r_ovf_acc <= 1'b0;
               r_cnt     <= '0;
               r_state   <= S_SHIFT;
            end
            S_SHIFT: begin
               r_bcd <= {w_adj[c_bcd_w-2:0], r_bin[WIDTH-1]};
               r_bin <= r_bin << 1;
               // A carry out of the top nibble means num >= 10^DIGITS
               if (w_adj[c_bcd_w-1])
                  r_ovf_acc <= 1'b1;
               if (r_cnt == c_cw'(WIDTH - 1))
                  r_state <= S_LOAD;
               else
                  r_cnt <= r_cnt + c_cw'(1);
            end
            S_LOAD: begin
               r_disp  <= r_bcd;
               r_ovf   <= r_ovf_acc;
               upd     <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= c_iw'(DIGITS - 1);
      end else if (r_presc == c_pw'(REFRESH_DIV - 1)) begin
         r_presc <= '0;
         r_idx   <= (r_idx == '0) ? c_iw'(DIGITS - 1) : r_idx - c_iw'(1);
      end else begin
         r_presc <= r_presc + c_pw'(1);
      end
   end

`ifdef SEG_LZB_EN
   logic [DIGITS-1:0] w_lz;
   logic              w_zrun;

   // w_lz[i] set when digit i and everything above it is zero; digit 0 always shown
   always_comb begin
      w_lz   = '0;
      w_zrun = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zrun  = w_zrun && (r_disp[4*i +: 4] == 4'd0);
         w_lz[i] = w_zrun && (i != 0);
      end
   end
`endif

   always_comb begin
      w_digit  = '0;
      w_dp     = 1'b0;
      w_onehot = '0;
      w_lzb    = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == c_iw'(i)) begin
            w_digit     = r_disp[4*i +: 4];
            w_dp        = dp[i];
            w_onehot[i] = 1'b1;
`ifdef SEG_LZB_EN
            w_lzb       = w_lz[i];
`endif
         end
      end
   end

   assign w_seg = r_ovf ? 7'b0000001 : (w_lzb ? 7'b0000000 : seg7(w_digit));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anodes   <= '0;
         cathodes <= 8'hFF;
      end else begin
         anodes   <= blank ? '0 : w_onehot;
         cathodes <= ~{w_seg, w_dp};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_bin
// Brief    : Directed-vector bench for seg_scan_bin (4-digit/16-bit and 2-digit/8-bit).
// Revision : 1.0
// ============================================================================
module tb_seg_scan_bin;

   logic        clk;
   logic        rst_n;
   logic [15:0] num;
   logic [3:0]  dp;
   logic        blank;
   logic [3:0]  anodes;
   logic [7:0]  cathodes;
   logic        upd;

   logic [7:0]  num2;
   logic [1:0]  anodes2;
   logic [7:0]  cathodes2;
   logic        upd2;

   int vectors = 0;
   int errors  = 0;

   seg_scan_bin #(.DIGITS(4), .WIDTH(16), .REFRESH_DIV(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .num(num), .dp(dp), .blank(blank),
      .anodes(anodes), .cathodes(cathodes), .upd(upd)
   );

   seg_scan_bin #(.DIGITS(2), .WIDTH(8), .REFRESH_DIV(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .num(num2), .dp(2'b00), .blank(1'b0),
      .anodes(anodes2), .cathodes(cathodes2), .upd(upd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_upd(input bit which, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 64) begin
         @(posedge clk); #1;
         n++;
         ok = which ? upd2 : upd;
      end
   endtask

   // Records the cathode pattern seen while each anode is lit over one full scan
   task automatic capture(output logic [3:0][7:0] c);
      c = 'x;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++)
            if (anodes == (4'b0001 << i)) c[i] = cathodes;
      end
   endtask

   task automatic capture2(output logic [1:0][7:0] c);
      c = 'x;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++)
            if (anodes2 == (2'b01 << i)) c[i] = cathodes2;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; num = 16'd1234; num2 = 8'd255; dp = 4'b0000; blank = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (anodes !== 4'b0000 || cathodes !== 8'hFF || upd !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: anodes=%b cathodes=%h upd=%b, want 0000/ff/0", anodes, cathodes, upd);
      end
   endtask

   task automatic test_scan_1234;
      logic [3:0]      exp_an;
      logic            exp_upd;
      logic [3:0][7:0] c;
      logic [3:0][7:0] e;
      rst_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         exp_an  = 4'b1000 >> (((k - 1) / 4) % 4);
         exp_upd = (k == 18 || k == 36);
         vectors++;
         if (anodes !== exp_an || upd !== exp_upd) begin
            errors++;
            $display("FAIL scan_timing k=%0d: anodes=%b upd=%b, want %b/%b", k, anodes, upd, exp_an, exp_upd);
         end
      end
      capture(c);
      e = {8'h9F, 8'h25, 8'h0D, 8'h99};
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (c[i] !== e[i]) begin
            errors++;
            $display("FAIL digits_1234 d%0d: cathodes=%h, want %h", i, c[i], e[i]);
         end
      end
   endtask

   task automatic test_overflow;
      int n; bit ok;
      logic [3:0][7:0] c;
      wait_upd(0, n, ok);
      num = 16'd9999;
      wait_upd(0, n, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL upd_9999: upd=0, want 1 within 64 cycles"); end
      capture(c);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (c[i] !== 8'h09) begin
            errors++;
            $display("FAIL digits_9999 d%0d: cathodes=%h, want 09", i, c[i]);
         end
      end
      wait_upd(0, n, ok);
      num = 16'd10000;
      wait_upd(0, n, ok);
      capture(c);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (c[i] !== 8'hFD) begin
            errors++;
            $display("FAIL overflow_10000 d%0d: cathodes=%h, want fd", i, c[i]);
         end
      end
   endtask

   task automatic test_dp_lzb;
      int n; bit ok;
      logic [3:0][7:0] c;
      logic [3:0][7:0] e;
      wait_upd(0, n, ok);
      num = 16'd42; dp = 4'b0100;
      wait_upd(0, n, ok);
      capture(c);
`ifdef SEG_LZB_EN
      e = {8'hFF, 8'hFE, 8'h99, 8'h25};
`else
      e = {8'h03, 8'h02, 8'h99, 8'h25};
`endif
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (c[i] !== e[i]) begin
            errors++;
            $display("FAIL digits_42dp d%0d: cathodes=%h, want %h", i, c[i], e[i]);
         end
      end
      wait_upd(0, n, ok);
      num = 16'd0; dp = 4'b0000;
      wait_upd(0, n, ok);
      capture(c);
`ifdef SEG_LZB_EN
      e = {8'hFF, 8'hFF, 8'hFF, 8'h03};
`else
      e = {8'h03, 8'h03, 8'h03, 8'h03};
`endif
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (c[i] !== e[i]) begin
            errors++;
            $display("FAIL digits_zero d%0d: cathodes=%h, want %h", i, c[i], e[i]);
         end
      end
   endtask

   task automatic test_inflight;
      int n; bit ok;
      logic [3:0][7:0] c;
      logic [3:0][7:0] e;
      wait_upd(0, n, ok);
      num = 16'd1234;
      repeat (5) @(posedge clk);
      #1 num = 16'd8888;
      wait_upd(0, n, ok);
      capture(c);
      e = {8'h9F, 8'h25, 8'h0D, 8'h99};
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (c[i] !== e[i]) begin
            errors++;
            $display("FAIL inflight_1234 d%0d: cathodes=%h, want %h", i, c[i], e[i]);
         end
      end
   endtask

   task automatic test_blank;
      logic [3:0] prev;
      logic [3:0] exp_an;
      int         s;
      bit         found;
      prev  = anodes;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(posedge clk); #1;
         if (anodes !== prev) found = 1'b1;
      end
      s = -1;
      for (int i = 0; i < 4; i++) if (anodes == (4'b0001 << i)) s = i;
      vectors++;
      if (!found || s < 0) begin
         errors++;
         $display("FAIL blank_sync: anodes=%b, want a slot change within 8 cycles", anodes);
      end
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         exp_an = (k >= 3 && k <= 12) ? 4'b0000 : 4'(4'b0001 << ((s - k / 4 + 8) % 4));
         vectors++;
         if (anodes !== exp_an) begin
            errors++;
            $display("FAIL blank_scan k=%0d: anodes=%b, want %b", k, anodes, exp_an);
         end
         if (k == 2)  blank = 1'b1;
         if (k == 12) blank = 1'b0;
      end
   endtask

   task automatic test_reset_midconv;
      int n; bit ok;
      logic [3:0][7:0] c;
      logic [3:0][7:0] e;
      num = 16'd5678;
      wait_upd(0, n, ok);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if (anodes !== 4'b0000 || cathodes !== 8'hFF || upd !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: anodes=%b cathodes=%h upd=%b, want 0000/ff/0", anodes, cathodes, upd);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_upd(0, n, ok);
      vectors++;
      if (!ok || n != 18) begin
         errors++;
         $display("FAIL reset_first_upd: cycles=%0d seen=%0d, want 18/1", n, ok);
      end
      capture(c);
      e = {8'h49, 8'h41, 8'h1F, 8'h01};
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (c[i] !== e[i]) begin
            errors++;
            $display("FAIL digits_5678 d%0d: cathodes=%h, want %h", i, c[i], e[i]);
         end
      end
   endtask

   task automatic test_small_params;
      int n; bit ok;
      logic [1:0][7:0] c;
      num2 = 8'd255;
      wait_upd(1, n, ok);
      wait_upd(1, n, ok);
      capture2(c);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (c[i] !== 8'hFD) begin
            errors++;
            $display("FAIL ovf_255 d%0d: cathodes=%h, want fd", i, c[i]);
         end
      end
      wait_upd(1, n, ok);
      num2 = 8'd99;
      wait_upd(1, n, ok);
      vectors++;
      if (!ok || n != 10) begin
         errors++;
         $display("FAIL upd_period_w8: cycles=%0d seen=%0d, want 10/1", n, ok);
      end
      capture2(c);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (c[i] !== 8'h09) begin
            errors++;
            $display("FAIL digits_99 d%0d: cathodes=%h, want 09", i, c[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_1234();
      test_overflow();
      test_dp_lzb();
      test_inflight();
      test_blank();
      test_reset_midconv();
      test_small_params();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
